datapath_seq: RTL and testbench

Parametrised, self-sequencing successor to the 16-bit datapath. It holds a WIDTH x NREGS register file, A/B operand registers, a shifter, a 4-op ALU, a C result register and a 3-bit status register (Z/N/V). It also has a small internal sequencer: one `start` pulse with a latched operation runs read-A, read-B, execute and writeback without per-cycle enables from the controller. It sits between the instruction decoder/FSM and memory/IO in the CPU.

---
 rtl/datapath_pkg.sv | 30 +++
 rtl/regfile_param.sv | 30 +++
 rtl/datapath_seq.sv | 208 ++++++++++++++++++++
 tb/tb_datapath_seq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared types and constants for the sequenced datapath
package datapath_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_MVN = 2'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        SH_PASS = 2'd0,
        SH_LSL  = 2'd1,
        SH_LSR  = 2'd2,
        SH_ASR  = 2'd3
    } shift_op_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        EXEC = 3'd3,
        WB   = 3'd4
    } state_t;

    localparam int Z_BIT = 0;
    localparam int V_BIT = 1;
    localparam int N_BIT = 2;

endpackage

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - register file, one sync write port, one comb read port
module regfile_param #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [$clog2(NREGS)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data,
    input  logic                     wr_en,
    input  logic [$clog2(NREGS)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data
);

    logic [WIDTH-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // NREGS is a power of two, so every address is in range
    assign rd_data = regs[rd_addr];

endmodule

// File: rtl/datapath_seq.sv
// rtl/datapath_seq.sv - register file, shifter, ALU and status run by a start-pulse sequencer
module datapath_seq
    import datapath_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int IMM_W = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [$clog2(NREGS)-1:0] rd,
    input  logic [$clog2(NREGS)-1:0] rn,
    input  logic [$clog2(NREGS)-1:0] rm,
    input  logic [1:0]               shift_op,
    input  logic [1:0]               alu_op,
    input  logic                     zero_a,
    input  logic                     use_imm,
    input  logic [IMM_W-1:0]         imm,
    input  logic                     write_rd,
    input  logic                     write_status,
    input  logic                     ext_wr_en,
    input  logic [$clog2(NREGS)-1:0] ext_wr_addr,
    input  logic [WIDTH-1:0]         ext_wr_data,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH-1:0]         dp_out,
    output logic [2:0]               status
);

    localparam int AW = $clog2(NREGS);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    function automatic logic [WIDTH-1:0] shift_b(input logic [WIDTH-1:0] b,
                                                 input shift_op_t op);
        logic [WIDTH-1:0] r;
        r = b;
        case (op)
            SH_PASS: r = b;
            SH_LSL:  r = {b[WIDTH-2:0], 1'b0};
            SH_LSR:  r = {1'b0, b[WIDTH-1:1]};
            SH_ASR:  r = {b[WIDTH-1], b[WIDTH-1:1]};
            default: r = b;
        endcase
        return r;
    endfunction

    // Returns {V, result}
    function automatic logic [WIDTH:0] alu(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input alu_op_t op);
        logic [WIDTH-1:0] r;
        logic             v;
        r = '0;
        v = 1'b0;
        case (op)
            ALU_ADD: begin
                r = a + b;
                v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                r = a + ~b + ONE;
                v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND: r = a & b;
            ALU_MVN: r = ~b;
            default: r = '0;
        endcase
        return {v, r};
    endfunction

    state_t state_q, state_d;

    logic [AW-1:0]    rd_q, rn_q, rm_q;
    shift_op_t        shift_op_q;
    alu_op_t          alu_op_q;
    logic             zero_a_q, use_imm_q, write_rd_q, write_status_q;
    logic [IMM_W-1:0] imm_q;

    logic [WIDTH-1:0] a_q, b_q, c_q;
    logic [2:0]       status_q;
    logic             done_q;

    logic [AW-1:0]    rf_raddr;
    logic [WIDTH-1:0] rf_rdata;
    logic             rf_wen;
    logic [AW-1:0]    rf_waddr;
    logic [WIDTH-1:0] rf_wdata;

    logic [WIDTH-1:0] alu_a, alu_b;
    logic [WIDTH:0]   alu_out;
    logic [WIDTH-1:0] alu_res;
    logic             flag_z, flag_n, flag_v;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RD_A;
            RD_A:    state_d = RD_B;
            RD_B:    state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // External writes only land in IDLE, so they never collide with writeback
    always_comb begin
        rf_raddr = (state_q == RD_B) ? rm_q : rn_q;
        rf_wen   = 1'b0;
        rf_waddr = ext_wr_addr;
        rf_wdata = ext_wr_data;
        if (state_q == IDLE && ext_wr_en) begin
            rf_wen = 1'b1;
        end else if (state_q == WB && write_rd_q) begin
            rf_wen   = 1'b1;
            rf_waddr = rd_q;
            rf_wdata = c_q;
        end
    end

    regfile_param #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_rf (
        .clk     (clk),
        .reset   (reset),
        .rd_addr (rf_raddr),
        .rd_data (rf_rdata),
        .wr_en   (rf_wen),
        .wr_addr (rf_waddr),
        .wr_data (rf_wdata)
    );

    always_comb begin
        alu_a   = zero_a_q ? '0 : a_q;
        alu_b   = use_imm_q ? {{(WIDTH-IMM_W){imm_q[IMM_W-1]}}, imm_q}
                            : shift_b(b_q, shift_op_q);
        alu_out = alu(alu_a, alu_b, alu_op_q);
        alu_res = alu_out[WIDTH-1:0];
        flag_v  = alu_out[WIDTH];
        flag_z  = (alu_res == '0);
        flag_n  = alu_res[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q           <= '0;
            rn_q           <= '0;
            rm_q           <= '0;
            shift_op_q     <= SH_PASS;
            alu_op_q       <= ALU_ADD;
            zero_a_q       <= 1'b0;
            use_imm_q      <= 1'b0;
            imm_q          <= '0;
            write_rd_q     <= 1'b0;
            write_status_q <= 1'b0;
            a_q            <= '0;
            b_q            <= '0;
            c_q            <= '0;
            status_q       <= '0;
            done_q         <= 1'b0;
        end else begin
            done_q <= (state_q == WB);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rd_q           <= rd;
                        rn_q           <= rn;
                        rm_q           <= rm;
                        shift_op_q     <= shift_op_t'(shift_op);
                        alu_op_q       <= alu_op_t'(alu_op);
                        zero_a_q       <= zero_a;
                        use_imm_q      <= use_imm;
                        imm_q          <= imm;
                        write_rd_q     <= write_rd;
                        write_status_q <= write_status;
                    end
                end
                RD_A: a_q <= rf_rdata;
                RD_B: b_q <= rf_rdata;
                EXEC: begin
                    c_q <= alu_res;
                    if (write_status_q) begin
                        status_q[Z_BIT] <= flag_z;
                        status_q[V_BIT] <= flag_v;
                        status_q[N_BIT] <= flag_n;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign dp_out = c_q;
    assign status = status_q;

endmodule

// File: tb/tb_datapath_seq.sv
// tb/tb_datapath_seq.sv - directed self-checking bench for datapath_seq
module tb_datapath_seq;

    localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_AND = 2'd2, OP_MVN = 2'd3;
    localparam logic [1:0] SH_P = 2'd0, SH_L = 2'd1, SH_R = 2'd2, SH_A = 2'd3;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [2:0]  rd, rn, rm;
    logic [1:0]  shift_op, alu_op;
    logic        zero_a, use_imm;
    logic [4:0]  imm;
    logic        write_rd, write_status, ext_wr_en;
    logic [2:0]  ext_wr_addr;
    logic [15:0] ext_wr_data;
    logic        busy, done;
    logic [15:0] dp_out;
    logic [2:0]  status;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    datapath_seq dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rd           (rd),
        .rn           (rn),
        .rm           (rm),
        .shift_op     (shift_op),
        .alu_op       (alu_op),
        .zero_a       (zero_a),
        .use_imm      (use_imm),
        .imm          (imm),
        .write_rd     (write_rd),
        .write_status (write_status),
        .ext_wr_en    (ext_wr_en),
        .ext_wr_addr  (ext_wr_addr),
        .ext_wr_data  (ext_wr_data),
        .busy         (busy),
        .done         (done),
        .dp_out       (dp_out),
        .status       (status)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [1:0] op, input logic [1:0] sh,
                          input logic [2:0] d, input logic [2:0] n, input logic [2:0] m,
                          input logic za, input logic ui, input logic [4:0] im,
                          input logic wr, input logic ws);
        alu_op = op; shift_op = sh; rd = d; rn = n; rm = m;
        zero_a = za; use_imm = ui; imm = im; write_rd = wr; write_status = ws;
    endtask

    // Pulses start and waits (bounded) for done; lat counts edges after E0
    task automatic launch(output int lat);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 12) begin
            tick();
            lat++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL op_timeout done=%b required=1", done);
        end
    endtask

    task automatic ext_write(input logic [2:0] addr, input logic [15:0] data);
        ext_wr_en = 1'b1; ext_wr_addr = addr; ext_wr_data = data;
        tick();
        ext_wr_en = 1'b0;
    endtask

    task automatic read_reg(input logic [2:0] idx, output logic [15:0] val);
        int lat;
        set_op(OP_ADD, SH_P, 3'd0, 3'd0, idx, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        launch(lat);
        val = dp_out;
    endtask

    task automatic test_reset;
        logic [15:0] v;
        reset = 1'b1; start = 1'b0; ext_wr_en = 1'b0; ext_wr_addr = '0; ext_wr_data = '0;
        set_op(OP_ADD, SH_P, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick(); tick();
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (dp_out !== 16'h0) begin errors++; $display("FAIL reset_dp_out got=%h exp=0000", dp_out); end
        checks++; if (status !== 3'b000) begin errors++; $display("FAIL reset_status got=%b exp=000", status); end
        read_reg(3'd3, v);
        checks++; if (v !== 16'h0) begin errors++; $display("FAIL reset_r3 got=%h exp=0000", v); end
    endtask

    task automatic test_add;
        int lat;
        logic [15:0] v;
        ext_write(3'd0, 16'd7);
        ext_write(3'd1, 16'd2);
        set_op(OP_ADD, SH_P, 3'd2, 3'd0, 3'd1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        launch(lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL add_latency got=%0d exp=4", lat); end
        checks++; if (dp_out !== 16'd9) begin errors++; $display("FAIL add_dp_out got=%h exp=0009", dp_out); end
        checks++; if (status !== 3'b000) begin errors++; $display("FAIL add_status got=%b exp=000", status); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got=%b exp=0", done); end
        read_reg(3'd2, v);
        checks++; if (v !== 16'd9) begin errors++; $display("FAIL add_r2 got=%h exp=0009", v); end
    endtask

    task automatic test_sub;
        int lat;
        logic [15:0] v;
        set_op(OP_SUB, SH_P, 3'd2, 3'd1, 3'd1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        launch(lat);
        checks++; if (dp_out !== 16'd0) begin errors++; $display("FAIL sub_dp_out got=%h exp=0000", dp_out); end
        checks++; if (status !== 3'b001) begin errors++; $display("FAIL sub_status got=%b exp=001", status); end
        read_reg(3'd2, v);
        checks++; if (v !== 16'd9) begin errors++; $display("FAIL sub_r2_kept got=%h exp=0009", v); end
    endtask

    task automatic test_overflow;
        int lat;
        ext_write(3'd3, 16'h7FFF);
        set_op(OP_ADD, SH_P, 3'd0, 3'd3, 3'd0, 1'b0, 1'b1, 5'b00001, 1'b0, 1'b1);
        launch(lat);
        checks++; if (dp_out !== 16'h8000) begin errors++; $display("FAIL ovf_dp_out got=%h exp=8000", dp_out); end
        checks++; if (status !== 3'b110) begin errors++; $display("FAIL ovf_status got=%b exp=110", status); end
        // negative immediate: 7 + (-1)
        set_op(OP_ADD, SH_P, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 5'b11111, 1'b0, 1'b1);
        launch(lat);
        checks++; if (dp_out !== 16'd6) begin errors++; $display("FAIL imm_neg_dp_out got=%h exp=0006", dp_out); end
        checks++; if (status !== 3'b000) begin errors++; $display("FAIL imm_neg_status got=%b exp=000", status); end
    endtask

    task automatic test_shifts;
        int lat;
        ext_write(3'd4, 16'h8001);
        set_op(OP_MVN, SH_A, 3'd0, 3'd0, 3'd4, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
        launch(lat);
        checks++; if (dp_out !== 16'h3FFF) begin errors++; $display("FAIL asr_dp_out got=%h exp=3fff", dp_out); end
        checks++; if (status !== 3'b000) begin errors++; $display("FAIL asr_status got=%b exp=000", status); end
        set_op(OP_MVN, SH_L, 3'd0, 3'd0, 3'd4, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
        launch(lat);
        checks++; if (dp_out !== 16'hFFFD) begin errors++; $display("FAIL lsl_dp_out got=%h exp=fffd", dp_out); end
        checks++; if (status !== 3'b100) begin errors++; $display("FAIL lsl_status got=%b exp=100", status); end
        set_op(OP_MVN, SH_R, 3'd0, 3'd0, 3'd4, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        launch(lat);
        checks++; if (dp_out !== 16'hBFFF) begin errors++; $display("FAIL lsr_dp_out got=%h exp=bfff", dp_out); end
        // R4 & R3 = 8001 & 7FFF
        set_op(OP_AND, SH_P, 3'd0, 3'd4, 3'd3, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        launch(lat);
        checks++; if (dp_out !== 16'h0001) begin errors++; $display("FAIL and_dp_out got=%h exp=0001", dp_out); end
        checks++; if (status !== 3'b000) begin errors++; $display("FAIL and_status got=%b exp=000", status); end
    endtask

    task automatic test_ext_with_start;
        int lat;
        ext_wr_en = 1'b1; ext_wr_addr = 3'd1; ext_wr_data = 16'd10;
        set_op(OP_ADD, SH_P, 3'd0, 3'd0, 3'd1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0; ext_wr_en = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 12) begin
            tick();
            lat++;
        end
        checks++; if (dp_out !== 16'd17 || done !== 1'b1) begin
            errors++; $display("FAIL ext_with_start got=%h done=%b exp=0011 done=1", dp_out, done);
        end
    endtask

    task automatic test_back_to_back_ignore;
        int dones;
        logic [15:0] v;
        set_op(OP_ADD, SH_P, 3'd5, 3'd0, 3'd1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        start = 1'b1;
        tick();
        rd = 3'd6; rn = 3'd4;
        ext_wr_en = 1'b1; ext_wr_addr = 3'd7; ext_wr_data = 16'hAAAA;
        tick(); tick(); tick();
        start = 1'b0; ext_wr_en = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        checks++; if (dones !== 1) begin errors++; $display("FAIL busy_done_count got=%0d exp=1", dones); end
        checks++; if (dp_out !== 16'd17) begin errors++; $display("FAIL busy_dp_out got=%h exp=0011", dp_out); end
        read_reg(3'd5, v);
        checks++; if (v !== 16'd17) begin errors++; $display("FAIL busy_r5 got=%h exp=0011", v); end
        read_reg(3'd6, v);
        checks++; if (v !== 16'd0) begin errors++; $display("FAIL busy_r6 got=%h exp=0000", v); end
        read_reg(3'd7, v);
        checks++; if (v !== 16'd0) begin errors++; $display("FAIL busy_r7 got=%h exp=0000", v); end
    endtask

    task automatic test_reset_mid_op;
        int dones, lat;
        logic [15:0] v;
        set_op(OP_ADD, SH_P, 3'd6, 3'd0, 3'd1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b exp=1", busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || dp_out !== 16'h0 || status !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset_outputs got busy=%b done=%b dp=%h st=%b exp all 0", busy, done, dp_out, status);
        end
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL mid_no_done got=%0d exp=0", dones); end
        read_reg(3'd6, v);
        checks++; if (v !== 16'd0) begin errors++; $display("FAIL mid_r6 got=%h exp=0000", v); end
        ext_write(3'd0, 16'd3);
        ext_write(3'd1, 16'd4);
        set_op(OP_ADD, SH_P, 3'd6, 3'd0, 3'd1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        launch(lat);
        checks++; if (lat !== 4 || dp_out !== 16'd7) begin
            errors++; $display("FAIL post_reset_op got lat=%0d dp=%h exp lat=4 dp=0007", lat, dp_out);
        end
        read_reg(3'd6, v);
        checks++; if (v !== 16'd7) begin errors++; $display("FAIL post_reset_r6 got=%h exp=0007", v); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_shifts();
        test_ext_with_start();
        test_back_to_back_ignore();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
